// File: rtl/pwm_duty_meter.sv
// rtl/pwm_duty_meter.sv - measures active time and period of a PWM input in clk cycles
module pwm_duty_meter #(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned TIMEOUT    = 16'hFFFF,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic             meas_valid,
   output logic             stuck,
   output logic             stuck_level
);

   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ACTIVE, INACTIVE} state_t;

   state_t           state;
   logic             sync1, sync2, hist;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] hi_tmp;
   logic             timed_out;

   logic lvl, lvl_prev, rise, fall, at_timeout;

   assign lvl        = sync2 ^ ACTIVE_LOW;
   assign lvl_prev   = hist ^ ACTIVE_LOW;
   assign rise       = lvl & ~lvl_prev;
   assign fall       = ~lvl & lvl_prev;
   assign at_timeout = (cnt == TMO);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1       <= ACTIVE_LOW;
         sync2       <= ACTIVE_LOW;
         hist        <= ACTIVE_LOW;
         cnt         <= '0;
         hi_tmp      <= '0;
         high_cnt    <= '0;
         period_cnt  <= '0;
         meas_valid  <= 1'b0;
         stuck       <= 1'b0;
         stuck_level <= 1'b0;
         timed_out   <= 1'b0;
         state       <= IDLE;
      end else begin
         sync1      <= pwm_in;
         sync2      <= sync1;
         hist       <= sync2;
         meas_valid <= 1'b0;

         if (rise)
            cnt <= CNT_W'(1);
         else if (!at_timeout)
            cnt <= cnt + CNT_W'(1);

         if (fall)
            hi_tmp <= cnt;

         // An edge always takes priority over a timeout in the same cycle.
         if (rise) begin
            timed_out <= 1'b0;
            if (state == INACTIVE) begin
               high_cnt   <= hi_tmp;
               period_cnt <= cnt;
               stuck      <= 1'b0;
               meas_valid <= 1'b1;
            end
            state <= ACTIVE;
         end else if (fall) begin
            if (state == ACTIVE)
               state <= INACTIVE;
         end else if (at_timeout && !timed_out) begin
            // cnt stays saturated afterwards; timed_out blocks repeat reports until a rise.
            high_cnt    <= lvl ? TMO : '0;
            period_cnt  <= TMO;
            stuck       <= 1'b1;
            stuck_level <= lvl;
            meas_valid  <= 1'b1;
            timed_out   <= 1'b1;
            state       <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// tb/tb_pwm_duty_meter.sv - self-checking bench for pwm_duty_meter
module tb_pwm_duty_meter;

   localparam int TO = 200;

   logic        clk = 1'b0;
   logic        rst;
   logic        pwm_a, pwm_b;
   logic [15:0] ha, pa, hb, pb;
   logic        va, sa, la, vb, sb, lb;

   pwm_duty_meter #(.CNT_W(16), .TIMEOUT(TO), .ACTIVE_LOW(1'b1)) dut_a (
      .clk(clk), .rst(rst), .pwm_in(pwm_a), .high_cnt(ha), .period_cnt(pa),
      .meas_valid(va), .stuck(sa), .stuck_level(la));

   pwm_duty_meter #(.CNT_W(16), .TIMEOUT(TO), .ACTIVE_LOW(1'b0)) dut_b (
      .clk(clk), .rst(rst), .pwm_in(pwm_b), .high_cnt(hb), .period_cnt(pb),
      .meas_valid(vb), .stuck(sb), .stuck_level(lb));

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;
   int printed = 0;

   task automatic check(string name, longint got, longint exp);
      checks++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Reference model: timestamps of the last rise give the elapsed count directly.
   typedef struct {
      bit s1, s2, s3;
      int base;
      int phase;    // 0 no rise yet, 1 in active part, 2 in inactive part
      bit tout;
      int hi;
      int high, period;
      bit valid, stuck, slvl;
   } mstate_t;

   mstate_t m[2];
   int      cyc = 0;
   bit      model_ok = 0;

   task automatic model_step(int d, bit raw, bit r);
      bit al, lv, pv;
      int c;
      al = (d == 0);
      m[d].valid = 0;
      if (r) begin
         m[d].s1 = al; m[d].s2 = al; m[d].s3 = al;
         m[d].base = cyc + 1; m[d].phase = 0; m[d].tout = 0; m[d].hi = 0;
         m[d].high = 0; m[d].period = 0; m[d].stuck = 0; m[d].slvl = 0;
         return;
      end
      lv = m[d].s2 ^ al;
      pv = m[d].s3 ^ al;
      c  = cyc - m[d].base;
      if (c > TO) c = TO;
      if (c < 0)  c = 0;
      if (lv && !pv) begin
         if (m[d].phase == 2) begin
            m[d].high = m[d].hi; m[d].period = c; m[d].stuck = 0; m[d].valid = 1;
         end
         m[d].phase = 1; m[d].base = cyc; m[d].tout = 0;
      end else if (!lv && pv) begin
         m[d].hi = c;
         if (m[d].phase == 1) m[d].phase = 2;
      end else if (c == TO && !m[d].tout) begin
         m[d].high = lv ? TO : 0; m[d].period = TO; m[d].stuck = 1;
         m[d].slvl = lv; m[d].valid = 1; m[d].phase = 0; m[d].tout = 1;
      end
      m[d].s3 = m[d].s2; m[d].s2 = m[d].s1; m[d].s1 = raw;
   endtask

   always @(posedge clk) begin
      cyc++;
      model_step(0, pwm_a, rst);
      model_step(1, pwm_b, rst);
      if (rst) model_ok = 1;
   end

   always @(negedge clk) begin
      logic [34:0] got [2];
      logic [34:0] exp [2];
      if (model_ok) begin
         got[0] = {ha, pa, va, sa, la};
         got[1] = {hb, pb, vb, sb, lb};
         for (int d = 0; d < 2; d++) begin
            exp[d] = {16'(m[d].high), 16'(m[d].period), m[d].valid, m[d].stuck, m[d].slvl};
            checks++;
            if (got[d] !== exp[d]) begin
               fails++;
               if (printed < 20) begin
                  printed++;
                  $display("FAIL model_%0d cycle %0d: got %h expected %h", d, cyc, got[d], exp[d]);
               end
            end
         end
      end
   end

   typedef struct { int high; int period; bit stuck; bit slvl; } report_t;
   report_t rep_q[$];
   bit      prev_va = 0;

   always @(negedge clk) begin
      if (va === 1'b1) begin
         rep_q.push_back('{int'(ha), int'(pa), sa, la});
         check("no_back_to_back_valid", prev_va, 0);
      end
      prev_va = (va === 1'b1);
   end

   task automatic drive_a(bit v, int n);
      repeat (n) begin
         @(negedge clk);
         pwm_a = v;
      end
   endtask

   // DUT a is active-low: 0 is the active level.
   task automatic wave_a(int act, int inact, int reps);
      repeat (reps) begin
         drive_a(1'b0, act);
         drive_a(1'b1, inact);
      end
   endtask

   task automatic check_zero(string name);
      check(name, {ha, pa, va, sa, la}, 0);
   endtask

   task automatic pulse_reset(string name);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_zero(name);
      rst = 1'b0;
   endtask

   task automatic check_rep(string name, int idx, int h, int p, bit s, bit l);
      if (idx < rep_q.size()) begin
         check({name, "_high"},   rep_q[idx].high,   h);
         check({name, "_period"}, rep_q[idx].period, p);
         check({name, "_stuck"},  rep_q[idx].stuck,  s);
         if (s) check({name, "_level"}, rep_q[idx].slvl, l);
      end
   endtask

   typedef struct {
      int act, inact, reps, n_rep;
      int first_h, first_p, rest_h, rest_p;
   } row_t;

   bit done = 0;

   initial begin : rand_b
      bit v;
      int len;
      v = 1'b0;
      pwm_b = 1'b0;
      while (!done) begin
         if ($urandom_range(0, 11) == 0) len = $urandom_range(230, 260);
         else                            len = $urandom_range(1, 40);
         repeat (len) begin
            @(negedge clk);
            pwm_b = v;
         end
         v = ~v;
      end
   end

   initial begin : main
      row_t    rows [4];
      report_t exp_q[$];

      rows[0] = '{20, 43, 4, 3, 20, 63, 20, 63};
      rows[1] = '{50, 13, 4, 4, 20, 63, 50, 63};
      rows[2] = '{10, 10, 4, 4, 50, 63, 10, 20};
      rows[3] = '{ 1,  1, 6, 6, 10, 20,  1,  2};

      rst   = 1'b1;
      pwm_a = 1'b1;
      repeat (3) @(negedge clk);
      check_zero("reset_state");
      rst = 1'b0;
      rep_q.delete();

      foreach (rows[i]) begin
         wave_a(rows[i].act, rows[i].inact, rows[i].reps);
         for (int k = 0; k < rows[i].n_rep; k++)
            exp_q.push_back(k == 0 ? '{rows[i].first_h, rows[i].first_p, 1'b0, 1'b0}
                                   : '{rows[i].rest_h,  rows[i].rest_p,  1'b0, 1'b0});
      end
      drive_a(1'b1, 10);
      check("rows_report_count", rep_q.size(), exp_q.size());
      foreach (exp_q[i])
         check_rep($sformatf("rows_rep%0d", i), i, exp_q[i].high, exp_q[i].period, 1'b0, 1'b0);

      pulse_reset("reset_before_stuck");
      rep_q.delete();
      drive_a(1'b1, 5);
      drive_a(1'b0, 1200);
      check("stuck_active_count", rep_q.size(), 1);
      check_rep("stuck_active", 0, TO, TO, 1'b1, 1'b1);

      rep_q.delete();
      drive_a(1'b1, 20);
      drive_a(1'b0, 20);
      drive_a(1'b1, 1200);
      check("stuck_inactive_count", rep_q.size(), 1);
      check_rep("stuck_inactive", 0, 0, TO, 1'b1, 1'b0);

      rep_q.delete();
      wave_a(20, 43, 3);
      drive_a(1'b1, 10);
      check("resume_count", rep_q.size(), 2);
      check_rep("resume0", 0, 20, 63, 1'b0, 1'b0);
      check_rep("resume1", 1, 20, 63, 1'b0, 1'b0);

      wave_a(20, 43, 2);
      drive_a(1'b0, 10);
      pulse_reset("reset_mid_period");
      rep_q.delete();
      drive_a(1'b0, 10);
      drive_a(1'b1, 43);
      wave_a(20, 43, 3);
      drive_a(1'b1, 10);
      check("after_reset_count", rep_q.size(), 3);
      check_rep("after_reset1", 1, 20, 63, 1'b0, 1'b0);
      check_rep("after_reset2", 2, 20, 63, 1'b0, 1'b0);

      done = 1;
      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
